mem_lsu_master: RTL
===================

Name: mem_lsu_master

Overview:
- Load/store initiator for the MEM stage of the 5-stage RV64 pipeline.
- Drives the read/write port (port 1) of the dual-port data memory.
- Converts byte-addressed B/H/W/D loads and stores into word-granular memory accesses:
  - sub-word stores use read-modify-write;
  - loads are sign- or zero-extended;
  - accesses that cross a 64-bit word boundary are split into two beats.

Parameters:
- ADR_WIDTH, 16: memory word-address width; byte address bits [ADR_WIDTH+2:3] select the word.
- DATA_WIDTH, 64: memory word width. Only 64 is supported.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request.
- req_we, input, 1: 1 = store, 0 = load.
- req_addr, input, 64: byte address.
- req_size, input, 2: 0 = B, 1 = H, 2 = W, 3 = D.
- req_unsigned, input, 1: zero-extend load result (LBU/LHU/LWU).
- req_wdata, input, 64: store data, right-aligned.
- rsp_valid, output, 1: single-cycle completion pulse.
- rsp_rdata, output, 64: extended load data; 0 for stores.
- rsp_err, output, 1: access rejected (see Optional Feature).
- mem_we, output, 1: memory write enable.
- mem_adr, output, ADR_WIDTH: memory word address.
- mem_wdata, output, DATA_WIDTH: merged write word.
- mem_rdata, input, DATA_WIDTH: asynchronous read data for mem_adr.

Behaviour:
- Reset (async, rst_n=0):
  - state := IDLE;
  - req_ready=1;
  - rsp_valid, rsp_rdata, rsp_err, mem_we, mem_adr, mem_wdata all 0;
  - latched request cleared.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1;
  - on req_valid && req_ready (cycle T), latch addr/size/we/unsigned/wdata and go to BEAT0.
  - req_ready=0 in every other state. A held req_valid waits; it is neither dropped nor duplicated.
- Access geometry:
  - n = 1 << size bytes;
  - off = addr[2:0];
  - w = addr[ADR_WIDTH+2:3]; higher address bits are ignored (modulo wrap).
  - split = (off + n > 8).
- BEAT0 (cycle T+1):
  - mem_adr = w.
  - Load: capture mem_rdata as lo.
  - Store: mem_wdata = mem_rdata with bytes off..min(7, off+n-1) replaced by wdata bytes; mem_we=1 for this cycle only.
  - Next state: BEAT1 if split, else RESP.
- BEAT1 (split only, T+2):
  - mem_adr = w+1, wrapping from 2^ADR_WIDTH-1 to 0.
  - Load: capture hi.
  - Store: bytes 0..(off+n-9) replaced by the remaining high wdata bytes; mem_we=1.
  - Next state: RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle. Timing: T+2 when not split, T+3 when split.
  - Load: rsp_rdata = ({hi,lo} >> 8*off) truncated to n bytes, then sign-extended (req_unsigned=0) or zero-extended. D loads ignore req_unsigned.
  - Store: rsp_rdata = 0.
  - Next state: IDLE.
- Throughput:
  - one request per 3 cycles (non-split) or 4 cycles (split);
  - no response backpressure.
- mem_we is 0 in IDLE and RESP. mem_adr holds its last value when idle.
- Reset mid-operation:
  - takes effect immediately: mem_we drops, no rsp_valid.
  - A split store reset after BEAT0 leaves word w modified and word w+1 untouched. This is acceptable; the pipeline flushes on reset.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - An access with addr not a multiple of n is not performed: no mem_we.
  - The FSM goes IDLE -> RESP directly: rsp_valid=1, rsp_err=1, rsp_rdata=0 at T+1.
  - BEAT1 is unreachable.
- MISALIGN_TRAP_EN undefined:
  - rsp_err tied 0;
  - misaligned accesses are serviced, including two-beat splits.

Test Plan:
Preload word0=0x8877665544332211, word1=0xFFEEDDCCBBAA9988 for all scenarios.
1. LW addr 0x4 signed -> rsp_valid at T+2; rsp_rdata=0xFFFFFFFF88776655; mem_we never 1.
2. LBU addr 0x7 -> rsp_rdata=0x0000000000000088; same request with req_unsigned=0 -> 0xFFFFFFFFFFFFFF88.
3. SH addr 0x2, wdata 0x000000000000BEEF -> mem_we=1 for exactly one cycle; word0=0x88776655BEEF2211; rsp_rdata=0.
4. LD addr 0x6:
   - macro undefined -> mem_adr 0 then 1; rsp_valid at T+3; rsp_rdata=0xDDCCBBAA99888877.
   - macro defined -> rsp_valid at T+1 with rsp_err=1; no memory access.
5. SD addr 0x7FFF8 with ADR_WIDTH=16, offset 0 -> mem_adr=0xFFFF; then LD addr 0x80000 -> reads word 0 (address wrap).
6. Split SW addr 0x6, wdata 0xCAFEF00D, rst_n pulsed low during BEAT1:
   - mem_we drops immediately; no rsp_valid;
   - req_ready=1 after release; word0 bytes 6..7 = 0x0D,0xF0; word1 unchanged.

Source files
------------

// File: rtl/mem_lsu_master.sv
// mem_lsu_master: MEM-stage load/store initiator for the RV64 pipeline.
// Turns byte-addressed B/H/W/D requests into 64-bit word accesses on the
// read/write port of the data memory. Sub-word stores are read-modify-write.
// Accesses crossing a word boundary take two beats (w, then w+1 with wrap).
// Loads are sign- or zero-extended.
// Build option: define MISALIGN_TRAP_EN to reject accesses whose address is
// not a multiple of the access size. Such a request answers with rsp_err one
// cycle after acceptance and touches no memory. Without the macro, rsp_err is
// tied low and misaligned accesses are serviced.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so a held
// req_valid simply waits. rsp_valid is a one-cycle pulse with no backpressure.
module mem_lsu_master #(
  parameter int ADR_WIDTH  = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [63:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [63:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [63:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [ADR_WIDTH-1:0]  mem_adr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADR_WIDTH+2:0]   addr_q;
  logic [1:0]             size_q;
  logic                   we_q;
  logic                   uns_q;
  logic [63:0]            wdata_q;
  logic [63:0]            lo_q;
  logic [63:0]            hi_q;
  logic [ADR_WIDTH-1:0]   adr_q;

  logic [2:0]             off;
  logic [ADR_WIDTH-1:0]   word_adr;
  logic [ADR_WIDTH-1:0]   word_adr_nxt;
  logic [3:0]             nbytes;
  logic                   split;
  logic [7:0]             lane_n;
  logic [15:0]            lane_mask;
  logic [127:0]           bit_mask;
  logic [127:0]           wide_wdata;
  logic [63:0]            merged_lo;
  logic [63:0]            merged_hi;
  logic [63:0]            raw_load;
  logic [63:0]            ext_load;
  logic                   accept;

  // Address bits above the word index wrap away by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[63:ADR_WIDTH+3];

`ifdef MISALIGN_TRAP_EN
  logic       err_q;
  logic [2:0] align_in;
  logic       misaligned_in;
`endif

  assign off          = addr_q[2:0];
  assign word_adr     = addr_q[ADR_WIDTH+2:3];
  assign word_adr_nxt = word_adr + {{(ADR_WIDTH-1){1'b0}}, 1'b1};
  assign accept       = req_valid && req_ready;
  assign dbg_state    = state_q;

`ifdef MISALIGN_TRAP_EN
  // Low address bits that must be zero for the incoming access size
  always_comb begin
    case (req_size)
      2'd0:    align_in = 3'b000;
      2'd1:    align_in = 3'b001;
      2'd2:    align_in = 3'b011;
      default: align_in = 3'b111;
    endcase
    misaligned_in = |(req_addr[2:0] & align_in);
  end
`endif

  // Byte-lane geometry, store merge words and load extraction
  always_comb begin
    nbytes = 4'd1 << size_q;
    split  = ({1'b0, off} + nbytes) > 4'd8;
    case (size_q)
      2'd0:    lane_n = 8'h01;
      2'd1:    lane_n = 8'h03;
      2'd2:    lane_n = 8'h0F;
      default: lane_n = 8'hFF;
    endcase
    // Lanes of the two-word window {w+1, w} that this access covers.
    lane_mask = {8'd0, lane_n} << off;
    for (int i = 0; i < 16; i++) begin
      bit_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    wide_wdata = {64'd0, wdata_q} << {off, 3'b000};
    merged_lo  = (mem_rdata & ~bit_mask[63:0])   | (wide_wdata[63:0]   & bit_mask[63:0]);
    merged_hi  = (mem_rdata & ~bit_mask[127:64]) | (wide_wdata[127:64] & bit_mask[127:64]);
    // For non-split loads hi_q is stale but falls outside the kept bytes.
    raw_load   = 64'({hi_q, lo_q} >> {off, 3'b000});
    case (size_q)
      2'd0:    ext_load = uns_q ? {56'd0, raw_load[7:0]}  : {{56{raw_load[7]}},  raw_load[7:0]};
      2'd1:    ext_load = uns_q ? {48'd0, raw_load[15:0]} : {{48{raw_load[15]}}, raw_load[15:0]};
      2'd2:    ext_load = uns_q ? {32'd0, raw_load[31:0]} : {{32{raw_load[31]}}, raw_load[31:0]};
      default: ext_load = raw_load;
    endcase
  end

  // FSM next state and all handshake / memory port outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = adr_q;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = BEAT0;
`ifdef MISALIGN_TRAP_EN
          if (misaligned_in) state_d = RESP;
`endif
        end
      end
      BEAT0: begin
        mem_adr = word_adr;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = merged_lo;
        end
        state_d = split ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_adr = word_adr_nxt;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = merged_hi;
        end
        state_d = RESP;
      end
      default: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? 64'd0 : ext_load;
`ifdef MISALIGN_TRAP_EN
        if (err_q) begin
          rsp_err   = 1'b1;
          rsp_rdata = 64'd0;
        end
`endif
        state_d = IDLE;
      end
    endcase
  end

  // State register, request latch, beat capture and held memory address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      adr_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr[ADR_WIDTH+2:0];
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
`ifdef MISALIGN_TRAP_EN
        err_q   <= misaligned_in;
`endif
      end
      if (state_q == BEAT0) begin
        lo_q  <= mem_rdata;
        adr_q <= mem_adr;
      end
      if (state_q == BEAT1) begin
        hi_q  <= mem_rdata;
        adr_q <= mem_adr;
      end
    end
  end

endmodule
